// File: rtl/accelerator_dnc_pkg.sv
// Shared definitions for the DNC accelerator pipeline stages: FSM state encodings
// and the zero/one constants used for counters and data words.
package accelerator_dnc_pkg;

    localparam int DNC_DATA_SIZE    = 64;
    localparam int DNC_CONTROL_SIZE = 64;

    typedef enum logic [1:0] {
        STARTER_STATE = 2'd0,
        MODE_STATE    = 2'd1,
        WEIGHT_STATE  = 2'd2
    } dnc_state_t;

    localparam logic [DNC_CONTROL_SIZE-1:0] ZERO_CONTROL = '0;
    localparam logic [DNC_CONTROL_SIZE-1:0] ONE_CONTROL  = {{(DNC_CONTROL_SIZE-1){1'b0}}, 1'b1};
    localparam logic [DNC_DATA_SIZE-1:0]    ZERO_DATA    = '0;
    localparam logic [DNC_DATA_SIZE-1:0]    ONE_DATA     = {{(DNC_DATA_SIZE-1){1'b0}}, 1'b1};

endpackage

// File: rtl/accelerator_read_weighting_mac.sv
// Combinational 3-term signed fixed-point dot product with rescale and saturation.
// Reusable wherever a weighted blend of three weightings is needed.
module accelerator_read_weighting_mac #(
    parameter int DATA_SIZE     = 64,
    parameter int FRACTION_SIZE = 32
) (
    input  logic [DATA_SIZE-1:0] pi_0,
    input  logic [DATA_SIZE-1:0] pi_1,
    input  logic [DATA_SIZE-1:0] pi_2,
    input  logic [DATA_SIZE-1:0] b,
    input  logic [DATA_SIZE-1:0] c,
    input  logic [DATA_SIZE-1:0] f,
    output logic [DATA_SIZE-1:0] weight
);

    localparam int PROD_SIZE = 2 * DATA_SIZE;
    localparam int SUM_SIZE  = 2 * DATA_SIZE + 2;
    localparam logic [DATA_SIZE-1:0] MAX_DATA = {1'b0, {(DATA_SIZE-1){1'b1}}};
    localparam logic [DATA_SIZE-1:0] MIN_DATA = {1'b1, {(DATA_SIZE-1){1'b0}}};

    logic signed [PROD_SIZE-1:0] pi_0_x, pi_1_x, pi_2_x, b_x, c_x, f_x;
    logic signed [PROD_SIZE-1:0] prod_b, prod_c, prod_f;
    logic signed [SUM_SIZE-1:0]  sum, shifted;
    logic [SUM_SIZE-DATA_SIZE:0] upper;
    logic                        overflow;

    // Sign-extend operands so each product is exact in PROD_SIZE bits.
    assign pi_0_x = {{DATA_SIZE{pi_0[DATA_SIZE-1]}}, pi_0};
    assign pi_1_x = {{DATA_SIZE{pi_1[DATA_SIZE-1]}}, pi_1};
    assign pi_2_x = {{DATA_SIZE{pi_2[DATA_SIZE-1]}}, pi_2};
    assign b_x    = {{DATA_SIZE{b[DATA_SIZE-1]}}, b};
    assign c_x    = {{DATA_SIZE{c[DATA_SIZE-1]}}, c};
    assign f_x    = {{DATA_SIZE{f[DATA_SIZE-1]}}, f};

    assign prod_b = pi_0_x * b_x;
    assign prod_c = pi_1_x * c_x;
    assign prod_f = pi_2_x * f_x;

    assign sum = {{2{prod_b[PROD_SIZE-1]}}, prod_b}
               + {{2{prod_c[PROD_SIZE-1]}}, prod_c}
               + {{2{prod_f[PROD_SIZE-1]}}, prod_f};

    assign shifted = sum >>> FRACTION_SIZE;

    // The result fits only when every bit above the output sign bit copies it.
    assign upper    = shifted[SUM_SIZE-1:DATA_SIZE-1];
    assign overflow = !((&upper) || !(|upper));

    always_comb begin
        weight = shifted[DATA_SIZE-1:0];
        if (overflow) begin
            weight = shifted[SUM_SIZE-1] ? MIN_DATA : MAX_DATA;
        end
    end

endmodule

// File: rtl/accelerator_read_weighting.sv
// DNC read weighting: per head, latch three read-mode coefficients, then blend each
// incoming backward/content/forward triple into one registered read weight.
module accelerator_read_weighting
    import accelerator_dnc_pkg::*;
#(
    parameter int DATA_SIZE     = 64,
    parameter int CONTROL_SIZE  = 64,
    parameter int FRACTION_SIZE = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic                 PI_IN_ENABLE,
    input  logic                 DATA_IN_ENABLE,
    output logic                 W_OUT_I_ENABLE,
    output logic                 W_OUT_J_ENABLE,
    input  logic [DATA_SIZE-1:0] SIZE_R_IN,
    input  logic [DATA_SIZE-1:0] SIZE_N_IN,
    input  logic [DATA_SIZE-1:0] PI_IN,
    input  logic [DATA_SIZE-1:0] B_IN,
    input  logic [DATA_SIZE-1:0] C_IN,
    input  logic [DATA_SIZE-1:0] F_IN,
    output logic [DATA_SIZE-1:0] W_OUT
);

    localparam logic [CONTROL_SIZE-1:0] CTRL_ZERO = CONTROL_SIZE'(ZERO_CONTROL);
    localparam logic [CONTROL_SIZE-1:0] CTRL_ONE  = CONTROL_SIZE'(ONE_CONTROL);
    localparam logic [CONTROL_SIZE-1:0] K_LAST    = CONTROL_SIZE'(2);
    localparam logic [DATA_SIZE-1:0]    DATA_ZERO = DATA_SIZE'(ZERO_DATA);

    dnc_state_t              state;
    logic [CONTROL_SIZE-1:0] i, j, k;
    logic [CONTROL_SIZE-1:0] size_r, size_n;
    logic [CONTROL_SIZE-1:0] last_i, last_j;
    logic [DATA_SIZE-1:0]    pi_0, pi_1, pi_2;
    logic [DATA_SIZE-1:0]    weight;

    assign last_i = size_r - CTRL_ONE;
    assign last_j = size_n - CTRL_ONE;

    accelerator_read_weighting_mac #(
        .DATA_SIZE    (DATA_SIZE),
        .FRACTION_SIZE(FRACTION_SIZE)
    ) mac (
        .pi_0  (pi_0),
        .pi_1  (pi_1),
        .pi_2  (pi_2),
        .b     (B_IN),
        .c     (C_IN),
        .f     (F_IN),
        .weight(weight)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state          <= STARTER_STATE;
            i              <= CTRL_ZERO;
            j              <= CTRL_ZERO;
            k              <= CTRL_ZERO;
            size_r         <= CTRL_ZERO;
            size_n         <= CTRL_ZERO;
            pi_0           <= DATA_ZERO;
            pi_1           <= DATA_ZERO;
            pi_2           <= DATA_ZERO;
            W_OUT          <= DATA_ZERO;
            READY          <= 1'b0;
            W_OUT_I_ENABLE <= 1'b0;
            W_OUT_J_ENABLE <= 1'b0;
        end else begin
            READY          <= 1'b0;
            W_OUT_I_ENABLE <= 1'b0;
            W_OUT_J_ENABLE <= 1'b0;
            case (state)
                STARTER_STATE: begin
                    if (START) begin
                        size_r <= CONTROL_SIZE'(SIZE_R_IN);
                        size_n <= CONTROL_SIZE'(SIZE_N_IN);
                        i      <= CTRL_ZERO;
                        j      <= CTRL_ZERO;
                        k      <= CTRL_ZERO;
                        // An empty problem completes at once without streaming.
                        if ((SIZE_R_IN == DATA_ZERO) || (SIZE_N_IN == DATA_ZERO)) begin
                            READY <= 1'b1;
                        end else begin
                            state <= MODE_STATE;
                        end
                    end
                end
                MODE_STATE: begin
                    if (PI_IN_ENABLE) begin
                        case (k[1:0])
                            2'd0:    pi_0 <= PI_IN;
                            2'd1:    pi_1 <= PI_IN;
                            default: pi_2 <= PI_IN;
                        endcase
                        if (k == K_LAST) begin
                            k     <= CTRL_ZERO;
                            state <= WEIGHT_STATE;
                        end else begin
                            k <= k + CTRL_ONE;
                        end
                    end
                end
                WEIGHT_STATE: begin
                    if (DATA_IN_ENABLE) begin
                        W_OUT          <= weight;
                        W_OUT_J_ENABLE <= 1'b1;
                        W_OUT_I_ENABLE <= (j == CTRL_ZERO);
                        if (j == last_j) begin
                            j <= CTRL_ZERO;
                            if (i == last_i) begin
                                READY <= 1'b1;
                                state <= STARTER_STATE;
                            end else begin
                                i     <= i + CTRL_ONE;
                                state <= MODE_STATE;
                            end
                        end else begin
                            j <= j + CTRL_ONE;
                        end
                    end
                end
                default: state <= STARTER_STATE;
            endcase
        end
    end

endmodule

// File: tb/tb_accelerator_read_weighting.sv
// Directed self-checking bench for accelerator_read_weighting with hand-computed
// fixed-point expectations (1.0 = 2^32) and an output scoreboard.
module tb_accelerator_read_weighting;

    localparam logic [63:0] ONE     = 64'h0000_0001_0000_0000;
    localparam logic [63:0] HALF    = 64'h0000_0000_8000_0000;
    localparam logic [63:0] QUARTER = 64'h0000_0000_4000_0000;
    localparam logic [63:0] THREEQ  = 64'h0000_0000_C000_0000;
    localparam logic [63:0] NEG_ONE = 64'hFFFF_FFFF_0000_0000;
    localparam logic [63:0] MAXV    = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV    = 64'h8000_0000_0000_0000;

    logic        CLK, RST, START, READY;
    logic        PI_IN_ENABLE, DATA_IN_ENABLE, W_OUT_I_ENABLE, W_OUT_J_ENABLE;
    logic [63:0] SIZE_R_IN, SIZE_N_IN, PI_IN, B_IN, C_IN, F_IN, W_OUT;

    int          test_count = 0;
    int          fail_count = 0;
    int          ready_count = 0;
    int          out_count = 0;
    int          ready_before;
    int          outs_before;

    logic [63:0] exp_w [$];
    logic        exp_i [$];
    logic        exp_last [$];

    accelerator_read_weighting dut (
        .CLK           (CLK),
        .RST           (RST),
        .START         (START),
        .READY         (READY),
        .PI_IN_ENABLE  (PI_IN_ENABLE),
        .DATA_IN_ENABLE(DATA_IN_ENABLE),
        .W_OUT_I_ENABLE(W_OUT_I_ENABLE),
        .W_OUT_J_ENABLE(W_OUT_J_ENABLE),
        .SIZE_R_IN     (SIZE_R_IN),
        .SIZE_N_IN     (SIZE_N_IN),
        .PI_IN         (PI_IN),
        .B_IN          (B_IN),
        .C_IN          (C_IN),
        .F_IN          (F_IN),
        .W_OUT         (W_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, actual, expected);
        end
    endtask

    // One cycle of stimulus: drive, let the DUT sample on the rising edge, drop strobes.
    task automatic applyStimulus(input logic st, input logic pe, input logic de,
                                 input logic [63:0] pi, input logic [63:0] b,
                                 input logic [63:0] c, input logic [63:0] f);
        START          = st;
        PI_IN_ENABLE   = pe;
        DATA_IN_ENABLE = de;
        PI_IN          = pi;
        B_IN           = b;
        C_IN           = c;
        F_IN           = f;
        @(posedge CLK);
        #1;
        START          = 1'b0;
        PI_IN_ENABLE   = 1'b0;
        DATA_IN_ENABLE = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic expectOut(input logic [63:0] w, input logic first, input logic last);
        exp_w.push_back(w);
        exp_i.push_back(first);
        exp_last.push_back(last);
    endtask

    task automatic beginOp(input logic [63:0] r, input logic [63:0] n);
        SIZE_R_IN    = r;
        SIZE_N_IN    = n;
        ready_before = ready_count;
        outs_before  = out_count;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic sendPi(input logic [63:0] p0, input logic [63:0] p1, input logic [63:0] p2);
        applyStimulus(1'b0, 1'b1, 1'b0, p0, '0, '0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, p1, '0, '0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, p2, '0, '0, '0);
    endtask

    // Bounded wait for READY, then confirm exactly one READY and a drained scoreboard.
    task automatic finishOp(input string tag, input int outs);
        for (int n = 0; n < 20; n++) begin
            if (ready_count > ready_before) break;
            @(negedge CLK);
            #1;
        end
        idle(2);
        checkOutput({tag, "_ready_count"}, 64'(ready_count - ready_before), 64'd1);
        checkOutput({tag, "_out_count"}, 64'(out_count - outs_before), 64'(outs));
        checkOutput({tag, "_drained"}, 64'(exp_w.size()), 64'd0);
        exp_w.delete();
        exp_i.delete();
        exp_last.delete();
    endtask

    task automatic scenarioOne();
        beginOp(64'd1, 64'd4);
        sendPi(ONE, '0, '0);
        expectOut(QUARTER, 1'b1, 1'b0);
        expectOut(HALF,    1'b0, 1'b0);
        expectOut(THREEQ,  1'b0, 1'b0);
        expectOut(ONE,     1'b0, 1'b1);
        for (int n = 1; n <= 4; n++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, '0, QUARTER * 64'(n), ONE, ONE);
        end
        finishOp("s1", 4);
    endtask

    // Scoreboard: every output pulse is checked against the next expected entry.
    always @(negedge CLK) begin
        if (RST) begin
            if (W_OUT_J_ENABLE) begin
                out_count++;
                checkOutput("expected_pending", 64'(exp_w.size() > 0), 64'd1);
                if (exp_w.size() > 0) begin
                    checkOutput("w_out", W_OUT, exp_w.pop_front());
                    checkOutput("i_enable", 64'(W_OUT_I_ENABLE), 64'(exp_i.pop_front()));
                    checkOutput("ready_with_last", 64'(READY), 64'(exp_last.pop_front()));
                end
            end else if (W_OUT_I_ENABLE) begin
                checkOutput("i_enable_without_j", 64'(W_OUT_I_ENABLE), 64'd0);
            end
            if (READY) ready_count++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        RST = 1'b1;
        START = 1'b0;
        PI_IN_ENABLE = 1'b0;
        DATA_IN_ENABLE = 1'b0;
        SIZE_R_IN = '0;
        SIZE_N_IN = '0;
        PI_IN = '0;
        B_IN = '0;
        C_IN = '0;
        F_IN = '0;
        #2 RST = 1'b0;
        #1;
        checkOutput("reset_w_out", W_OUT, 64'd0);
        checkOutput("reset_ready", 64'(READY), 64'd0);
        checkOutput("reset_i_en", 64'(W_OUT_I_ENABLE), 64'd0);
        checkOutput("reset_j_en", 64'(W_OUT_J_ENABLE), 64'd0);
        idle(2);
        RST = 1'b1;
        idle(1);

        scenarioOne();

        // Two heads, mode mix differs per head but all inputs are 1.0.
        beginOp(64'd2, 64'd2);
        sendPi(HALF, QUARTER, QUARTER);
        expectOut(ONE, 1'b1, 1'b0);
        expectOut(ONE, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, '0, ONE, ONE, ONE);
        applyStimulus(1'b0, 1'b0, 1'b1, '0, ONE, ONE, ONE);
        sendPi('0, '0, ONE);
        expectOut(ONE, 1'b1, 1'b0);
        expectOut(ONE, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, '0, ONE, ONE, ONE);
        applyStimulus(1'b0, 1'b0, 1'b1, '0, ONE, ONE, ONE);
        finishOp("s2", 4);

        // Saturation at both rails.
        beginOp(64'd1, 64'd1);
        sendPi(ONE, ONE, ONE);
        expectOut(MAXV, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, '0, MAXV, MAXV, MAXV);
        finishOp("s3_pos", 1);
        beginOp(64'd1, 64'd1);
        sendPi(NEG_ONE, NEG_ONE, NEG_ONE);
        expectOut(MINV, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, '0, MAXV, MAXV, MAXV);
        finishOp("s3_neg", 1);

        // Empty problems complete one cycle after START.
        beginOp(64'd1, 64'd0);
        checkOutput("s4_n0_ready", 64'(READY), 64'd1);
        idle(1);
        checkOutput("s4_n0_ready_pulse", 64'(READY), 64'd0);
        finishOp("s4_n0", 0);
        beginOp(64'd0, 64'd3);
        checkOutput("s4_r0_ready", 64'(READY), 64'd1);
        idle(1);
        checkOutput("s4_r0_ready_pulse", 64'(READY), 64'd0);
        finishOp("s4_r0", 0);

        // Strobe gating: wrong-state strobes and a stray START must have no effect.
        beginOp(64'd1, 64'd2);
        applyStimulus(1'b0, 1'b0, 1'b1, '0, ONE, ONE, ONE);
        SIZE_N_IN = 64'd3;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
        applyStimulus(1'b0, 1'b1, 1'b1, HALF, ONE, ONE, ONE);
        idle(2);
        applyStimulus(1'b0, 1'b1, 1'b0, QUARTER, '0, '0, '0);
        idle(1);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, '0, '0);
        expectOut(THREEQ, 1'b1, 1'b0);
        expectOut(HALF,   1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, '0, ONE, ONE, ONE);
        idle(1);
        applyStimulus(1'b0, 1'b1, 1'b0, ONE, '0, '0, '0);
        idle(1);
        applyStimulus(1'b0, 1'b0, 1'b1, '0, HALF, ONE, ONE);
        finishOp("s5", 2);

        // Reset mid-operation abandons the head; a fresh run then behaves normally.
        beginOp(64'd1, 64'd4);
        sendPi(ONE, '0, '0);
        expectOut(QUARTER, 1'b1, 1'b0);
        expectOut(HALF,    1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, '0, QUARTER, ONE, ONE);
        applyStimulus(1'b0, 1'b0, 1'b1, '0, HALF, ONE, ONE);
        @(negedge CLK);
        #1;
        RST = 1'b0;
        #1;
        checkOutput("s6_rst_w_out", W_OUT, 64'd0);
        checkOutput("s6_rst_j_en", 64'(W_OUT_J_ENABLE), 64'd0);
        checkOutput("s6_rst_i_en", 64'(W_OUT_I_ENABLE), 64'd0);
        checkOutput("s6_rst_ready", 64'(READY), 64'd0);
        idle(2);
        RST = 1'b1;
        idle(2);
        checkOutput("s6_no_ready", 64'(ready_count - ready_before), 64'd0);
        checkOutput("s6_partial_outs", 64'(out_count - outs_before), 64'd2);
        exp_w.delete();
        exp_i.delete();
        exp_last.delete();
        scenarioOne();

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
